// File: rtl/gerador_padrao_vga.sv
// VGA test-pattern generator: timing counters, registered syncs/DE/RGB, four patterns.
// Define VGA_BORDA_EN to force a one-pixel white alignment border around the active area.
module gerador_padrao_vga #(
   parameter int COLOR_W    = 10,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int QUAD_TAM   = 200,
   parameter int QUAD_X0    = 220,
   parameter int QUAD_Y0    = 140,
   parameter int VELOCIDADE = 2
) (
   input  logic                                            clock,
   input  logic                                            reset,
   input  logic [1:0]                                      modo,
   input  logic [3*COLOR_W-1:0]                            cor_fundo,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]    sx,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]    sy,
   output logic                                            de,
   output logic                                            inicio_quadro,
   output logic                                            vga_hsync,
   output logic                                            vga_vsync,
   output logic [COLOR_W-1:0]                              vga_r,
   output logic [COLOR_W-1:0]                              vga_g,
   output logic [COLOR_W-1:0]                              vga_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);
   localparam int HS_INI  = H_ACTIVE + H_FP;
   localparam int HS_FIM  = HS_INI + H_SYNC;
   localparam int VS_INI  = V_ACTIVE + V_FP;
   localparam int VS_FIM  = VS_INI + V_SYNC;
   localparam logic POL   = 1'(SYNC_POL);

   assert property (@(posedge clock) (QUAD_TAM < H_ACTIVE) && (QUAD_TAM < V_ACTIVE));

   logic [XW-1:0]        sx_q, sx_d, qx_q, qx_d, px;
   logic [YW-1:0]        sy_q, sy_d, qy_q, qy_d, py;
   logic                 dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards 0
   logic [1:0]           modo_q, modo_d;
   logic                 fim_linha, fim_quadro, ativo, dentro, hs_ativo, vs_ativo;
   logic [2:0]           barra;
   logic [3*COLOR_W-1:0] pix, pix_q;
   logic                 de_q, hs_q, vs_q;

   assign fim_linha  = (sx_q == XW'(H_TOTAL - 1));
   assign fim_quadro = fim_linha && (sy_q == YW'(V_TOTAL - 1));

   always_comb begin
      sx_d = fim_linha ? '0 : sx_q + XW'(1);
      sy_d = sy_q;
      if (fim_linha)
         sy_d = (sy_q == YW'(V_TOTAL - 1)) ? '0 : sy_q + YW'(1);
      modo_d = fim_quadro ? modo : modo_q;
   end

   // Square motion: clamp to the edge and reverse instead of overshooting.
   always_comb begin
      qx_d = qx_q;
      qy_d = qy_q;
      dx_d = dx_q;
      dy_d = dy_q;
      if (fim_quadro && modo_q == 2'd3) begin
         if (!dx_q) begin
            if ({1'b0, qx_q} + (XW+1)'(QUAD_TAM + VELOCIDADE) >= (XW+1)'(H_ACTIVE)) begin
               qx_d = XW'(H_ACTIVE - QUAD_TAM);
               dx_d = 1'b1;
            end else
               qx_d = qx_q + XW'(VELOCIDADE);
         end else begin
            if (qx_q <= XW'(VELOCIDADE)) begin
               qx_d = '0;
               dx_d = 1'b0;
            end else
               qx_d = qx_q - XW'(VELOCIDADE);
         end
         if (!dy_q) begin
            if ({1'b0, qy_q} + (YW+1)'(QUAD_TAM + VELOCIDADE) >= (YW+1)'(V_ACTIVE)) begin
               qy_d = YW'(V_ACTIVE - QUAD_TAM);
               dy_d = 1'b1;
            end else
               qy_d = qy_q + YW'(VELOCIDADE);
         end else begin
            if (qy_q <= YW'(VELOCIDADE)) begin
               qy_d = '0;
               dy_d = 1'b0;
            end else
               qy_d = qy_q - YW'(VELOCIDADE);
         end
      end
   end

   assign ativo    = (sx_q < XW'(H_ACTIVE)) && (sy_q < YW'(V_ACTIVE));
   assign hs_ativo = (sx_q >= XW'(HS_INI)) && (sx_q < XW'(HS_FIM));
   assign vs_ativo = (sy_q >= YW'(VS_INI)) && (sy_q < YW'(VS_FIM));
   assign px       = (modo_q == 2'd3) ? qx_q : XW'(QUAD_X0);
   assign py       = (modo_q == 2'd3) ? qy_q : YW'(QUAD_Y0);
   assign dentro   = (sx_q >= px) && ({1'b0, sx_q} < {1'b0, px} + (XW+1)'(QUAD_TAM)) &&
                     (sy_q >= py) && ({1'b0, sy_q} < {1'b0, py} + (YW+1)'(QUAD_TAM));

   // Bar index floor(sx*8/H_ACTIVE) via constant thresholds on sx*8.
   always_comb begin
      barra = '0;
      for (int i = 1; i < 8; i++)
         if ({sx_q, 3'b000} >= (XW+3)'(i * H_ACTIVE))
            barra = 3'(i);
   end

   always_comb begin
      case (modo_q)
         2'd0:    pix = cor_fundo;
         2'd2:    pix = {{COLOR_W{~barra[1]}}, {COLOR_W{~barra[2]}}, {COLOR_W{~barra[0]}}};
         default: pix = dentro ? '1 : cor_fundo;
      endcase
`ifdef VGA_BORDA_EN
      if (sx_q == '0 || sx_q == XW'(H_ACTIVE - 1) || sy_q == '0 || sy_q == YW'(V_ACTIVE - 1))
         pix = '1;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sx_q   <= '0;
         sy_q   <= '0;
         modo_q <= '0;
         qx_q   <= XW'(QUAD_X0);
         qy_q   <= YW'(QUAD_Y0);
         dx_q   <= 1'b0;
         dy_q   <= 1'b0;
         de_q   <= 1'b0;
         hs_q   <= ~POL;
         vs_q   <= ~POL;
         pix_q  <= '0;
      end else begin
         sx_q   <= sx_d;
         sy_q   <= sy_d;
         modo_q <= modo_d;
         qx_q   <= qx_d;
         qy_q   <= qy_d;
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         de_q   <= ativo;
         hs_q   <= hs_ativo ? POL : ~POL;
         vs_q   <= vs_ativo ? POL : ~POL;
         pix_q  <= ativo ? pix : '0;
      end
   end

   assign sx            = sx_q;
   assign sy            = sy_q;
   assign inicio_quadro = fim_quadro;
   assign de            = de_q;
   assign vga_hsync     = hs_q;
   assign vga_vsync     = vs_q;
   assign vga_r         = pix_q[3*COLOR_W-1:2*COLOR_W];
   assign vga_g         = pix_q[2*COLOR_W-1:COLOR_W];
   assign vga_b         = pix_q[COLOR_W-1:0];

endmodule

// File: tb/tb_gerador_padrao_vga.sv
// Directed bench for gerador_padrao_vga on a reduced 24x16 raster (frame = 384 clocks).
module tb_gerador_padrao_vga;
   localparam int CW = 10;
   localparam logic [CW-1:0] FULL = 10'h3FF;
   localparam logic [3*CW-1:0] BG = {10'h111, 10'h333, 10'h777};

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    modo = 2'd0;
   logic [3*CW-1:0] cor_fundo = '0;
   logic [4:0]    sx;
   logic [3:0]    sy;
   logic          de, inicio_quadro, vga_hsync, vga_vsync;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   int checks = 0;
   int failures = 0;

   gerador_padrao_vga #(
      .COLOR_W(CW), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0),
      .QUAD_TAM(4), .QUAD_X0(5), .QUAD_Y0(3), .VELOCIDADE(2)
   ) dut (
      .clock(clock), .reset(reset), .modo(modo), .cor_fundo(cor_fundo),
      .sx(sx), .sy(sy), .de(de), .inicio_quadro(inicio_quadro),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 clock = ~clock;

   task automatic wait_pos(input int x, input int y);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(sx == x && sy == y) && n < 1000);
      if (!(sx == x && sy == y)) begin
         checks++; failures++;
         $display("FAIL wait_pos timeout target=(%0d,%0d) at=(%0d,%0d)", x, y, sx, sy);
      end
   endtask

   task automatic wait_wrap();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!inicio_quadro && n < 1000);
      if (!inicio_quadro) begin
         checks++; failures++;
         $display("FAIL wait_wrap timeout");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      modo  = 2'd0;
      repeat (3) @(negedge clock);
      checks++; if (sx !== 5'd0) begin failures++; $display("FAIL reset_sx got=%0d exp=0", sx); end
      checks++; if (sy !== 4'd0) begin failures++; $display("FAIL reset_sy got=%0d exp=0", sy); end
      checks++; if (de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de); end
      checks++; if ({vga_r, vga_g, vga_b} !== 30'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=0", {vga_r, vga_g, vga_b}); end
      checks++; if ({vga_hsync, vga_vsync} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b exp=11", {vga_hsync, vga_vsync}); end
      checks++; if (inicio_quadro !== 1'b0) begin failures++; $display("FAIL reset_inicio got=%b exp=0", inicio_quadro); end
      reset = 1'b0;
   endtask

   task automatic test_timing();
      int hs_low = 0, vs_low = 0, de_cnt = 0, ini_cnt = 0, ini_at = 0;
      int hs_sx = -1, hs_run = 0, vs_sx = -1, vs_sy = -1;
      bit run_done = 0;
      wait_wrap();
      for (int i = 1; i <= 384; i++) begin
         @(negedge clock);
         if (!vga_hsync) begin
            hs_low++;
            if (hs_sx < 0) hs_sx = sx;
            if (!run_done) hs_run++;
         end else if (hs_run > 0) run_done = 1;
         if (!vga_vsync) begin
            vs_low++;
            if (vs_sy < 0) begin vs_sy = sy; vs_sx = sx; end
         end
         if (de) de_cnt++;
         if (inicio_quadro) begin ini_cnt++; ini_at = i; end
      end
      checks++; if (hs_low != 48) begin failures++; $display("FAIL hsync_low_cycles got=%0d exp=48", hs_low); end
      checks++; if (hs_run != 3) begin failures++; $display("FAIL hsync_width got=%0d exp=3", hs_run); end
      checks++; if (hs_sx != 19) begin failures++; $display("FAIL hsync_start_sx got=%0d exp=19", hs_sx); end
      checks++; if (vs_low != 48) begin failures++; $display("FAIL vsync_low_cycles got=%0d exp=48", vs_low); end
      checks++; if (vs_sy != 13 || vs_sx != 1) begin failures++; $display("FAIL vsync_start got=(%0d,%0d) exp=(1,13)", vs_sx, vs_sy); end
      checks++; if (de_cnt != 192) begin failures++; $display("FAIL de_count got=%0d exp=192", de_cnt); end
      checks++; if (ini_cnt != 1 || ini_at != 384) begin failures++; $display("FAIL inicio_period got=%0d@%0d exp=1@384", ini_cnt, ini_at); end
   endtask

   task automatic test_bars();
      modo = 2'd2;
      wait_wrap();
      wait_pos(2, 1); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== {FULL, FULL, 10'h0}) begin failures++; $display("FAIL bar_yellow got=%h", {vga_r, vga_g, vga_b}); end
      wait_pos(14, 1); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== 30'h0) begin failures++; $display("FAIL bar_black got=%h exp=0", {vga_r, vga_g, vga_b}); end
      wait_pos(12, 2); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== {10'h0, 10'h0, FULL}) begin failures++; $display("FAIL bar_blue got=%h", {vga_r, vga_g, vga_b}); end
      wait_pos(0, 3); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b, de} !== {FULL, FULL, FULL, 1'b1}) begin failures++; $display("FAIL bar_white got=%h de=%b", {vga_r, vga_g, vga_b}, de); end
      wait_pos(20, 3); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b, de} !== 31'h0) begin failures++; $display("FAIL bar_blank got=%h de=%b exp=0", {vga_r, vga_g, vga_b}, de); end
      wait_pos(7, 4); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== {10'h0, FULL, 10'h0}) begin failures++; $display("FAIL bar_green got=%h", {vga_r, vga_g, vga_b}); end
   endtask

   task automatic test_mode_latch();
      modo = 2'd0;
      cor_fundo = BG;
      wait_wrap();
      wait_pos(0, 2);
      modo = 2'd1;
      wait_pos(6, 4); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL latch_same_frame got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
      wait_wrap();
      wait_pos(5, 3); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== '1) begin failures++; $display("FAIL sq_corner_tl got=%h exp=all ones", {vga_r, vga_g, vga_b}); end
      wait_pos(6, 4); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== '1) begin failures++; $display("FAIL sq_inside got=%h exp=all ones", {vga_r, vga_g, vga_b}); end
      wait_pos(4, 5); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL sq_left_out got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
      wait_pos(9, 5); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL sq_right_excl got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
      wait_pos(8, 6); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== '1) begin failures++; $display("FAIL sq_corner_br got=%h exp=all ones", {vga_r, vga_g, vga_b}); end
      wait_pos(6, 7); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL sq_bottom_excl got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
      wait_pos(1, 8); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL sq_background got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
   endtask

   task automatic test_bounce();
      int exp_x [15] = '{5, 7, 9, 11, 12, 10, 8, 6, 4, 2, 0, 2, 4, 6, 8};
      int exp_y [15] = '{3, 5, 7, 8, 6, 4, 2, 0, 2, 4, 6, 8, 6, 4, 2};
      reset = 1'b1;
      modo  = 2'd3;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 15; n++) begin
         wait_wrap();
         @(negedge clock);
         checks++;
         if (dut.qx_q !== exp_x[n] || dut.qy_q !== exp_y[n]) begin
            failures++;
            $display("FAIL bounce_frame%0d got=(%0d,%0d) exp=(%0d,%0d)", n + 1, dut.qx_q, dut.qy_q, exp_x[n], exp_y[n]);
         end
      end
      wait_pos(8, 2); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== '1) begin failures++; $display("FAIL bounce_pixel_in got=%h exp=all ones", {vga_r, vga_g, vga_b}); end
      wait_pos(7, 3); @(negedge clock);
      checks++; if ({vga_r, vga_g, vga_b} !== BG) begin failures++; $display("FAIL bounce_pixel_out got=%h exp=%h", {vga_r, vga_g, vga_b}, BG); end
   endtask

   task automatic test_reset_mid();
      wait_pos(10, 5);
      reset = 1'b1;
      @(negedge clock);
      checks++; if (sx !== 5'd0 || sy !== 4'd0) begin failures++; $display("FAIL midreset_counters got=(%0d,%0d) exp=(0,0)", sx, sy); end
      checks++; if (dut.qx_q !== 5'd5 || dut.qy_q !== 4'd3) begin failures++; $display("FAIL midreset_pos got=(%0d,%0d) exp=(5,3)", dut.qx_q, dut.qy_q); end
      checks++; if (dut.modo_q !== 2'd0) begin failures++; $display("FAIL midreset_modo got=%0d exp=0", dut.modo_q); end
      checks++; if ({de, inicio_quadro, vga_hsync, vga_vsync} !== 4'b0011) begin failures++; $display("FAIL midreset_ctl got=%b exp=0011", {de, inicio_quadro, vga_hsync, vga_vsync}); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (sx !== 5'd1 || sy !== 4'd0) begin failures++; $display("FAIL midreset_restart got=(%0d,%0d) exp=(1,0)", sx, sy); end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_bars();
      test_mode_latch();
      test_bounce();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
